// File: rtl/result_bcd_convert_if.sv
// Valid/ready bus carrying a binary value into the BCD converter and the
// packed decimal result back out.
//   in_valid/in_ready/bin        : upstream handshake and binary operand
//   out_valid/out_ready/bcd/ndigits : downstream handshake and BCD result
// slave modport is the converter; master modport is the surrounding logic.
interface result_bcd_convert_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 10
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      bin;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic [3:0]            ndigits;

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, bcd, ndigits
   );

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, bcd, ndigits
   );
endinterface

// File: rtl/result_bcd_convert.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   io    : result_bcd_convert_if slave (in_valid/in_ready/bin,
//           out_valid/out_ready/bcd/ndigits)
// bcd digit 0 (units) sits in bits [3:0]; ndigits counts significant digits
// (1 for zero). bcd/ndigits only change when a conversion finishes.
module result_bcd_convert #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   result_bcd_convert_if.slave io
);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [WIDTH-1:0]   shreg_q,     shreg_d;
   logic [BCD_W-1:0]   acc_q,       acc_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [BCD_W-1:0]   bcd_q,       bcd_d;
   logic [3:0]         ndigits_q,   ndigits_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   acc_shift;
   logic [3:0]         nd_calc;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         ndigits_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         ndigits_q   <= ndigits_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state, one double-dabble step, and registered handshake decodes
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ndigits_d = ndigits_q;
      adj       = '0;
      nd_calc   = 4'd1;

      // Add-3 per digit, no carry between digits, then shift in next bit
      for (int i = 0; i < int'(DIGITS); i++) begin
         adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                   : acc_q[4*i +: 4];
      end
      acc_shift = {adj[BCD_W-2:0], shreg_q[WIDTH-1]};

      // Highest nonzero digit of the post-shift accumulator, floor of one
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc_shift[4*i +: 4] != 4'd0) nd_calc = 4'(i + 1);
      end

      case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               shreg_d = io.bin;
               acc_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d   = acc_shift;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d   = DONE;
               bcd_d     = acc_shift;
               ndigits_d = nd_calc;
            end
         end
         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = out_valid_q;
   assign io.bcd       = bcd_q;
   assign io.ndigits   = ndigits_q;
endmodule

// File: tb/tb_result_bcd_convert.sv
// Bench for result_bcd_convert: directed vectors, results checked through a
// scoreboard queue drained by an independent output monitor.
module tb_result_bcd_convert;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned DIGITS = 10;
   localparam int          BOUND  = 200;

   typedef struct packed {
      logic [4*DIGITS-1:0] bcd;
      logic [3:0]          nd;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   exp_t sb[$];

   result_bcd_convert_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   result_bcd_convert #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Output monitor: every completed output handshake pops one expectation
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got bcd %0h with no expected result",
                     bus.bcd);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_bcd", 64'(bus.bcd), 64'(e.bcd));
            check("sb_ndigits", 64'(bus.ndigits), 64'(e.nd));
         end
      end
   end

   // Present a value and hold in_valid until accepted; returns after accept edge + #1
   task automatic do_accept(input logic [WIDTH-1:0] v, input logic push,
                            input logic [4*DIGITS-1:0] eb, input logic [3:0] en);
      int n;
      exp_t e;
      bus.in_valid = 1'b1;
      bus.bin      = v;
      n = 0;
      while (!bus.in_ready && n < BOUND) begin
         @(posedge clk); #1; n++;
      end
      if (n >= BOUND) check("accept_timeout", 64'(n), 64'(0));
      if (push) begin
         e.bcd = eb;
         e.nd  = en;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Count edges until out_valid is seen (bounded)
   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < BOUND) begin
         @(posedge clk); #1; n++;
      end
      if (n >= BOUND) check("out_valid_timeout", 64'(n), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_checks      = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.bin       = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_bcd", 64'(bus.bcd), 64'(0));
      check("rst_ndigits", 64'(bus.ndigits), 64'(0));
      rst_n = 1'b1;

      // Zero: exact latency, single digit
      do_accept(32'd0, 1'b1, 40'h0, 4'd1);
      wait_valid(n);
      check("latency_zero", 64'(n), 64'(32));
      @(posedge clk); #1;
      check("zero_in_ready_after", 64'(bus.in_ready), 64'(1));
      check("zero_out_valid_after", 64'(bus.out_valid), 64'(0));

      // All ones: full ten digits
      do_accept(32'hFFFF_FFFF, 1'b1, 40'h42_9496_7295, 4'd10);
      wait_valid(n);
      check("latency_max", 64'(n), 64'(32));
      @(posedge clk); #1;

      // 123 with downstream stall for 5 cycles
      bus.out_ready = 1'b0;
      do_accept(32'd123, 1'b1, 40'h123, 4'd3);
      wait_valid(n);
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", 64'(bus.out_valid), 64'(1));
         check("stall_bcd", 64'(bus.bcd), 64'h123);
         check("stall_ndigits", 64'(bus.ndigits), 64'(3));
         check("stall_in_ready", 64'(bus.in_ready), 64'(0));
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release_in_ready", 64'(bus.in_ready), 64'(1));
      check("stall_release_out_valid", 64'(bus.out_valid), 64'(0));
      check("hold_bcd_after_hs", 64'(bus.bcd), 64'h123);
      check("hold_nd_after_hs", 64'(bus.ndigits), 64'(3));

      // Back-to-back: bin changes during SHIFT, next accept 34 edges later
      do_accept(32'd7, 1'b1, 40'h7, 4'd1);
      bus.in_valid = 1'b1;
      bus.bin      = 32'd10;
      n = 1;
      while (!bus.in_ready && n < BOUND) begin
         @(posedge clk); #1; n++;
      end
      // n counts edges since the first accept, minus the upcoming accept edge
      begin
         exp_t e;
         e.bcd = 40'h10;
         e.nd  = 4'd2;
         sb.push_back(e);
      end
      @(posedge clk); #1; n++;
      bus.in_valid = 1'b0;
      check("accept_spacing", 64'(n - 1), 64'(34));
      wait_valid(n);
      check("latency_ten", 64'(n), 64'(32));
      @(posedge clk); #1;

      // Reset during the 10th SHIFT cycle of 500 discards it
      do_accept(32'd500, 1'b0, 40'h0, 4'd0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
      check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
      check("midrst_bcd", 64'(bus.bcd), 64'(0));
      check("midrst_ndigits", 64'(bus.ndigits), 64'(0));
      #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) n++;
      end
      check("no_out_after_abort", 64'(n), 64'(0));

      do_accept(32'd99999, 1'b1, 40'h9_9999, 4'd5);
      wait_valid(n);
      check("latency_99999", 64'(n), 64'(32));
      @(posedge clk); #1;

      n = 0;
      while (sb.size() != 0 && n < BOUND) begin
         @(posedge clk); #1; n++;
      end
      check("scoreboard_drained", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
